// File: rtl/max_value_report_sequencer_pkg.sv
// Shared definitions for the max-value report sequencer: command and opcode bytes,
// FSM state encoding and the three-byte report frame layout.
package max_value_report_sequencer_pkg;

    localparam logic [7:0] CMD_CH1 = 8'h31;
    localparam logic [7:0] CMD_CH2 = 8'h32;
    localparam logic [7:0] CMD_CH3 = 8'h33;
    localparam logic [7:0] CMD_CH4 = 8'h34;

    localparam logic [7:0] OP_CH1 = 8'h41;
    localparam logic [7:0] OP_CH2 = 8'h42;
    localparam logic [7:0] OP_CH3 = 8'h43;
    localparam logic [7:0] OP_CH4 = 8'h44;

    localparam int FRAME_LEN = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_SEND   = 3'd2,
        ST_ACCEPT = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_ABORT  = 3'd5
    } state_t;

    // Byte idx of the report frame: opcode, then the 10-bit snapshot MSB-first.
    function automatic logic [7:0] frame_byte(input logic [1:0] idx,
                                              input logic [7:0] opcode,
                                              input logic [9:0] snap);
        case (idx)
            2'd0:    frame_byte = opcode;
            2'd1:    frame_byte = {6'b0, snap[9:8]};
            default: frame_byte = snap[7:0];
        endcase
    endfunction

endpackage

// File: rtl/max_value_report_sequencer_cmd_decode.sv
// Combinational decoder: received byte -> {valid, channel, opcode}.
module cmd_decode
    import max_value_report_sequencer_pkg::*;
(
    input  logic [7:0] rx_byte,
    output logic       valid,
    output logic [2:0] channel,
    output logic [7:0] opcode
);

    always_comb begin
        valid   = 1'b0;
        channel = 3'd0;
        opcode  = 8'h00;
        case (rx_byte)
            CMD_CH1: begin valid = 1'b1; channel = 3'd1; opcode = OP_CH1; end
            CMD_CH2: begin valid = 1'b1; channel = 3'd2; opcode = OP_CH2; end
            CMD_CH3: begin valid = 1'b1; channel = 3'd3; opcode = OP_CH3; end
            CMD_CH4: begin valid = 1'b1; channel = 3'd4; opcode = OP_CH4; end
            default: ;
        endcase
    end

endmodule

// File: rtl/max_value_report_sequencer.sv
// Turns UART channel commands into 3-byte max-value reports: select the cache channel,
// let it settle, snapshot the peak and hand the frame byte-by-byte to the transmitter.
module max_value_report_sequencer
    import max_value_report_sequencer_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int TX_TIMEOUT    = 65535
) (
    input  logic       clk,
    input  logic       reset_b,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    input  logic [9:0] max_value,
    output logic [2:0] chan_sel,
    output logic [7:0] tx_data,
    output logic       tx_en,
    input  logic       tx_ready,
    output logic       busy,
    output logic       cmd_err,
    output logic       overflow,
    output logic       timeout_err
);

    localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TX_TIMEOUT - 1);
    localparam logic [1:0]  LAST_IDX     = 2'(FRAME_LEN - 1);

    state_t      state, state_nxt;
    logic [1:0]  rst_sync;
    logic        run;
    logic        rx_vld_p0;
    logic [7:0]  rx_byte_p0;
    logic        dec_valid;
    logic [2:0]  dec_ch;
    logic [7:0]  dec_op;
    logic        rx_cmd;
    logic        pend_vld;
    logic [2:0]  pend_ch;
    logic [7:0]  pend_op;
    logic [7:0]  cur_op;
    logic [9:0]  snapshot;
    logic [1:0]  idx;
    logic [15:0] cnt;
    logic        settle_done;
    logic        tx_expired;

    // Reset release is re-timed to clk; the FSM stays idle until run rises.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign run = rst_sync[1];

    // Stage p0: register the received strobe/byte before decoding
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b)  rx_vld_p0 <= 1'b0;
        else           rx_vld_p0 <= rx_ready & run;
    end

    always_ff @(posedge clk) begin
        rx_byte_p0 <= rx_data;
    end

    cmd_decode u_cmd_decode (
        .rx_byte (rx_byte_p0),
        .valid   (dec_valid),
        .channel (dec_ch),
        .opcode  (dec_op)
    );

    assign rx_cmd      = rx_vld_p0 & dec_valid;
    assign settle_done = (cnt == SETTLE_LAST);
    assign tx_expired  = (cnt == TIMEOUT_LAST);

    // FSM state register
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b)  state <= ST_IDLE;
        else if (!run) state <= ST_IDLE;
        else           state <= state_nxt;
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (pend_vld || rx_cmd) state_nxt = ST_SETTLE;
            ST_SETTLE: if (settle_done) state_nxt = ST_SEND;
            ST_SEND: begin
                if (!tx_ready)       state_nxt = ST_ACCEPT;
                else if (tx_expired) state_nxt = ST_ABORT;
            end
            ST_ACCEPT: begin
                if (tx_ready)        state_nxt = ST_DRAIN;
                else if (tx_expired) state_nxt = ST_ABORT;
            end
            ST_DRAIN:  state_nxt = (idx == LAST_IDX) ? ST_IDLE : ST_SEND;
            ST_ABORT:  state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        tx_en       = (state == ST_SEND);
        busy        = (state != ST_IDLE);
        timeout_err = (state == ST_ABORT);
        cmd_err     = rx_vld_p0 & ~dec_valid;
    end

    // Datapath: pending slot, channel select, counters, snapshot and tx byte.
    // While run is low the FSM is pinned to IDLE and rx_cmd is low, so nothing here moves.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            pend_vld <= 1'b0;
            pend_ch  <= 3'd0;
            pend_op  <= 8'h00;
            overflow <= 1'b0;
            chan_sel <= 3'd0;
            cur_op   <= 8'h00;
            snapshot <= 10'd0;
            idx      <= 2'd0;
            cnt      <= 16'd0;
            tx_data  <= 8'h00;
        end else begin
            // A command is only started directly when IDLE has nothing pending
            if (rx_cmd && !(state == ST_IDLE && !pend_vld)) begin
                pend_vld <= 1'b1;
                pend_ch  <= dec_ch;
                pend_op  <= dec_op;
                if (pend_vld && state != ST_IDLE) overflow <= 1'b1;
            end else if (state == ST_IDLE && pend_vld) begin
                pend_vld <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    cnt <= 16'd0;
                    if (pend_vld) begin
                        chan_sel <= pend_ch;
                        cur_op   <= pend_op;
                    end else if (rx_cmd) begin
                        chan_sel <= dec_ch;
                        cur_op   <= dec_op;
                    end
                end
                ST_SETTLE: begin
                    if (settle_done) begin
                        snapshot <= max_value;
                        idx      <= 2'd0;
                        cnt      <= 16'd0;
                        tx_data  <= cur_op;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_SEND: begin
                    if (!tx_ready)       cnt      <= 16'd0;
                    else if (tx_expired) chan_sel <= 3'd0;
                    else                 cnt      <= cnt + 16'd1;
                end
                ST_ACCEPT: begin
                    if (tx_ready)        cnt      <= 16'd0;
                    else if (tx_expired) chan_sel <= 3'd0;
                    else                 cnt      <= cnt + 16'd1;
                end
                ST_DRAIN: begin
                    if (idx == LAST_IDX) begin
                        chan_sel <= 3'd0;
                    end else begin
                        idx     <= idx + 2'd1;
                        cnt     <= 16'd0;
                        tx_data <= frame_byte(idx + 2'd1, cur_op, snapshot);
                    end
                end
                default: chan_sel <= 3'd0;
            endcase
        end
    end

endmodule

// File: doc/max_value_report_sequencer.md
MAX_VALUE_REPORT_SEQUENCER -- requirements
Module: max_value_report_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4: clk cycles held after chan_sel changes before max_value is sampled; legal range 1..255.
REQ-002 Parameter TX_TIMEOUT, default 65535: clk cycles allowed per handshake phase before abort; legal range 2..65535.
REQ-003 clk  in  1  system clock; all logic rising-edge.
REQ-004 reset_b  in  1  asynchronous, active-low reset.
REQ-005 rx_data  in  8  received UART byte, valid only when rx_ready=1.
REQ-006 rx_ready  in  1  single-cycle strobe: new byte on rx_data.
REQ-007 max_value  in  10  cached peak for the channel selected by chan_sel.
REQ-008 chan_sel  out  3  cache channel select: 1..4 = channel, 0 = none.
REQ-009 tx_data  out  8  byte presented to the UART transmitter.
REQ-010 tx_en  out  1  transmit request, level.
REQ-011 tx_ready  in  1  UART idle/ready flag; high = idle.
REQ-012 busy  out  1  high whenever the FSM is not in IDLE.
REQ-013 cmd_err  out  1  single-cycle pulse: unrecognised command byte.
REQ-014 overflow  out  1  sticky flag: a pending command was overwritten.
REQ-015 timeout_err  out  1  single-cycle pulse: frame aborted on timeout.

Function
REQ-016 Valid commands: ASCII '1'..'4' (0x31..0x34), mapped to channels 1..4 and opcodes 0x41..0x44 ('A'..'D').
REQ-017 Any other byte strobed by rx_ready pulses cmd_err on the next cycle and queues nothing.
REQ-018 One-entry pending register; a valid command arriving while busy is stored in it.
REQ-019 A second valid command arriving while pending is full overwrites the entry and sets overflow.
REQ-020 The FSM has states IDLE, SETTLE, SEND, ACCEPT, DRAIN, ABORT.
REQ-021 IDLE: on a valid rx_ready, or a non-empty pending entry (pending has priority), load chan_sel, clear that pending entry, then go to SETTLE.
REQ-022 Simultaneous rx_ready and a non-empty pending entry in IDLE: serve pending; store the new command in pending (no overflow).
REQ-023 SETTLE: count SETTLE_CYCLES, then latch max_value into an internal 10-bit snapshot, set byte index 0, then go to SEND.
REQ-024 Frame = 3 bytes: index 0 = opcode; index 1 = {6'b0, snapshot[9:8]}; index 2 = snapshot[7:0].
REQ-025 SEND: drive tx_data = frame[index] and tx_en=1; when tx_ready=0 is sampled, go to ACCEPT.
REQ-026 ACCEPT: tx_en=0, hold tx_data; when tx_ready=1 is sampled, go to DRAIN.
REQ-027 DRAIN: if index<2, increment index and go to SEND; else set chan_sel=0 and go to IDLE.
REQ-028 Minimum latency, valid rx_ready to first tx_en high: SETTLE_CYCLES+2 cycles.
REQ-029 The timeout counter clears on entry to SEND and to ACCEPT; reaching TX_TIMEOUT in either state goes to ABORT.
REQ-030 ABORT (one cycle): pulse timeout_err, tx_en=0, chan_sel=0, discard the frame, keep the pending entry, go to IDLE.
REQ-031 tx_data holds its last value outside SEND/ACCEPT; tx_en is low in every state except SEND.
REQ-032 The snapshot is frozen for the whole frame; max_value changes after the SETTLE sample do not alter bytes 1 and 2.

Reset
REQ-033 reset_b low, at any time including mid-frame: state=IDLE, chan_sel=0, tx_data=0x00, tx_en=0, busy=0, cmd_err=0, overflow=0, timeout_err=0, pending empty, counters and snapshot zero.
REQ-034 Reset deassertion is synchronised to clk; the first state transition occurs no earlier than the second clk edge after release.
REQ-035 overflow clears only on reset.

Structure
REQ-036 The shared package holds the ASCII command constants, the opcode constants 0x41..0x44, the FSM state encoding, and the frame length (3).
REQ-037 One sub-module, cmd_decode, is natural: a combinational byte -> {valid, channel, opcode} decoder.

Verification
REQ-038 SETTLE_CYCLES=4, max_value=0x2A5, tx_ready handshake model; rx_data=0x32 -> chan_sel=2; bytes 0x42, 0x02, 0xA5 sent; busy falls; chan_sel=0.
REQ-039 rx_data=0x35 -> one-cycle cmd_err pulse; busy stays 0; tx_en stays 0.
REQ-040 Send '1', then '3' mid-frame, then '4' mid-frame -> overflow=1; second frame is opcode 0x44; channel 3 is never sent.
REQ-041 TX_TIMEOUT=16, tx_ready stuck at 1 -> timeout_err pulses 16 cycles after SEND entry; FSM returns to IDLE.
REQ-042 Assert reset_b low during byte index 1 -> all outputs at reset values immediately; after release, rx_data=0x31 sends a complete 0x41 frame.
REQ-043 max_value changes from 0x3FF to 0x000 during byte 0 -> bytes 1 and 2 are 0x03 and 0xFF.
